// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-to-RAM bus bridge.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RMW_MERGE
    } state_t;

    localparam logic [3:0]  BE_ALL   = 4'b1111;
    localparam logic [3:0]  BE_NONE  = 4'b0000;
    localparam int unsigned ADDR_LSB = 2;

endpackage

// File: rtl/mem_bus_bridge_byte_merge.sv
// Combinational byte-lane merge: enabled lanes take new_word, the rest keep old_word.
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges the byte-addressed CPU bus to a word-indexed single-port RAM,
// turning partial-word writes into read-modify-write sequences.
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [3:0]  cpu_byteenable,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,
    output logic        err,
    output logic [31:0] ram_address,
    output logic        ram_read,
    output logic        ram_write,
    output logic [3:0]  ram_byteenable,
    output logic [31:0] ram_writedata,
    input  logic [31:0] ram_readdata
);

    localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH_WORDS) << ADDR_LSB;

    state_t      state;
    logic [31:0] hold;
    logic        oor_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] offset;
    logic        in_window;
    logic        misaligned;
    logic        rd_req;
    logic        wr_req;
    logic        full_wr;
    logic        part_wr;
    logic        req_err;
    logic [31:0] rd_word;
    logic [31:0] merged;

    assign offset         = cpu_address - BASE_ADDR;
    assign in_window      = (cpu_address >= BASE_ADDR) && ({1'b0, offset} < WINDOW_BYTES);
    assign misaligned     = cpu_address[ADDR_LSB-1:0] != '0;
    assign rd_req         = cpu_read & ~cpu_write;
    assign wr_req         = cpu_write & ~cpu_read;
    assign full_wr        = wr_req && (cpu_byteenable == BE_ALL);
    assign part_wr        = wr_req && (cpu_byteenable != BE_ALL) && (cpu_byteenable != BE_NONE);
    assign req_err        = (cpu_read & cpu_write)
                          | ((rd_req | wr_req) & (misaligned | ~in_window));
    assign ram_address    = offset >> ADDR_LSB;
    assign ram_byteenable = BE_ALL;
    assign rd_word        = oor_q ? '0 : ram_readdata;

    // Merge uses latched write inputs so the RMW still lands if the CPU drops its request early.
    byte_merge u_merge (
        .old_word (ram_readdata),
        .new_word (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            err     <= 1'b0;
            hold    <= '0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_err) err <= 1'b1;
                    if (rd_req) begin
                        state <= RD_WAIT;
                        oor_q <= ~in_window;
                    end else if (part_wr && in_window) begin
                        state   <= RMW_MERGE;
                        wdata_q <= cpu_writedata;
                        be_q    <= cpu_byteenable;
                    end
                end
                RD_WAIT: begin
                    hold  <= rd_word;
                    state <= IDLE;
                end
                RMW_MERGE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_waitrequest = 1'b0;
        cpu_readdata    = hold;
        ram_read        = 1'b0;
        ram_write       = 1'b0;
        ram_writedata   = cpu_writedata;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    cpu_waitrequest = 1'b1;
                    ram_read        = in_window;
                end else if (part_wr && in_window) begin
                    cpu_waitrequest = 1'b1;
                    ram_read        = 1'b1;
                end else if (full_wr && in_window) begin
                    ram_write = 1'b1;
                end
            end
            RD_WAIT: cpu_readdata = rd_word;
            RMW_MERGE: begin
                ram_write     = 1'b1;
                ram_writedata = merged;
            end
            default: ;
        endcase
        if (!reset_n) begin
            ram_read  = 1'b0;
            ram_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge with a behavioural RAM and a read scoreboard.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic        err;
    logic [31:0] ram_address;
    logic        ram_read;
    logic        ram_write;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    logic [31:0] mem [0:4095];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mem_bus_bridge #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(4096)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cpu_address     (cpu_address),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_byteenable  (cpu_byteenable),
        .cpu_writedata   (cpu_writedata),
        .cpu_readdata    (cpu_readdata),
        .cpu_waitrequest (cpu_waitrequest),
        .err             (err),
        .ram_address     (ram_address),
        .ram_read        (ram_read),
        .ram_write       (ram_write),
        .ram_byteenable  (ram_byteenable),
        .ram_writedata   (ram_writedata),
        .ram_readdata    (ram_readdata)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_write) begin
            mem[ram_address[11:0]] <= ram_writedata;
            wr_cnt <= wr_cnt + 1;
        end
        if (ram_read) begin
            ram_readdata <= mem[ram_address[11:0]];
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a request at posedge+1, samples mid-cycle, returns after the completing edge.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data,
                        output int cycles, output logic [31:0] rdata);
        cpu_read       = rd;
        cpu_write      = wr;
        cpu_address    = addr;
        cpu_byteenable = be;
        cpu_writedata  = data;
        cycles = 0;
        rdata  = 'x;
        for (int i = 0; i < 8; i++) begin
            #4;
            cycles++;
            if (!cpu_waitrequest) begin
                rdata = cpu_readdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input int exp_cyc);
        int          c;
        logic [31:0] r;
        xfer(1'b0, 1'b1, addr, be, data, c, r);
        check({tag, "_cyc"}, c, exp_cyc);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        int          c;
        logic [31:0] r;
        logic [31:0] e;
        exp_q.push_back(exp);
        xfer(1'b1, 1'b0, addr, 4'b0000, 32'h0, c, r);
        e = exp_q.pop_front();
        check({tag, "_data"}, r, e);
        check({tag, "_cyc"}, c, 2);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int          c0;
        int          r0;
        int          w0;
        int          c;
        logic [31:0] r;
        cpu_address = '0; cpu_byteenable = '0; cpu_writedata = '0;
        do_reset();
        #4;
        check("rst_err", err, 0);
        check("rst_rdata", cpu_readdata, 32'h0);
        check("rst_wait", cpu_waitrequest, 0);
        check("rst_strobes", {ram_read, ram_write}, 2'b00);
        check("ram_be", ram_byteenable, 4'b1111);
        @(posedge clk); #1;

        wr_chk("pre200", 32'h200, 4'b1111, 32'h1122_3344, 1);
        wr_chk("pre300", 32'h300, 4'b1111, 32'h5555_5555, 1);
        wr_chk("pre400", 32'h400, 4'b1111, 32'h0102_0304, 1);
        wr_chk("pre600", 32'h600, 4'b1111, 32'h0000_0000, 1);

        wr_chk("full100", 32'h100, 4'b1111, 32'hDEAD_BEEF, 1);
        check("mem100", mem[12'h040], 32'hDEAD_BEEF);
        rd_chk("rd100", 32'h100, 32'hDEAD_BEEF);

        wr_chk("part200", 32'h200, 4'b0101, 32'hAABB_CCDD, 2);
        check("mem200", mem[12'h080], 32'h11BB_33DD);
        rd_chk("rd200", 32'h200, 32'h11BB_33DD);

        w0 = wr_cnt; r0 = rd_cnt;
        wr_chk("null300", 32'h300, 4'b0000, 32'hFFFF_FFFF, 1);
        check("null_wr", wr_cnt - w0, 0);
        check("null_rd", rd_cnt - r0, 0);
        check("mem300", mem[12'h0C0], 32'h5555_5555);
        check("null_err", err, 0);
        #4 check("hold", cpu_readdata, 32'h11BB_33DD);
        @(posedge clk); #1;

        c0 = cyc;
        rd_chk("b2b_rd1", 32'h100, 32'hDEAD_BEEF);
        wr_chk("b2b_part", 32'h400, 4'b1000, 32'hFF00_0000, 2);
        wr_chk("b2b_full", 32'h500, 4'b1111, 32'hCAFE_F00D, 1);
        rd_chk("b2b_rd2", 32'h400, 32'hFF02_0304);
        check("b2b_total", cyc - c0, 7);
        check("mem500", mem[12'h140], 32'hCAFE_F00D);

        w0 = wr_cnt; r0 = rd_cnt;
        xfer(1'b1, 1'b1, 32'h100, 4'b1111, 32'h0, c, r);
        check("both_cyc", c, 1);
        check("both_rdata", r, 32'hFF02_0304);
        check("both_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        check("both_err", err, 1);

        do_reset();
        r0 = rd_cnt;
        rd_chk("oor_rd", 32'h4000, 32'h0);
        check("oor_rd_strobe", rd_cnt - r0, 0);
        check("oor_err", err, 1);

        do_reset();
        w0 = wr_cnt; r0 = rd_cnt;
        wr_chk("oor_full", 32'h4000, 4'b1111, 32'h1234_5678, 1);
        wr_chk("oor_part", 32'h4004, 4'b0011, 32'h1234_5678, 1);
        check("oor_wr_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        check("oor_wr_err", err, 1);

        do_reset();
        check("clr_err", err, 0);
        rd_chk("mis_rd", 32'h103, 32'hDEAD_BEEF);
        check("mis_err", err, 1);

        cpu_address = 32'h500; cpu_byteenable = 4'b0001; cpu_writedata = 32'h0000_00AA;
        cpu_write = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #3 check("rst_rmw_wr", ram_write, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cpu_write = 1'b0;
        #3;
        check("rst_rmw_err", err, 0);
        check("rst_rmw_rdata", cpu_readdata, 32'h0);
        check("rst_rmw_wait", cpu_waitrequest, 0);
        check("rst_rmw_mem", mem[12'h140], 32'hCAFE_F00D);
        @(posedge clk); #1;

        cpu_address = 32'h600; cpu_byteenable = 4'b0011; cpu_writedata = 32'h0000_BEEF;
        cpu_write = 1'b1;
        @(posedge clk); #1;
        cpu_write = 1'b0; cpu_byteenable = 4'b0000; cpu_writedata = 32'h0;
        @(posedge clk); #1;
        check("drop_rmw_mem", mem[12'h180], 32'h0000_BEEF);
        rd_chk("drop_rmw_rd", 32'h600, 32'h0000_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits between the MIPS CPU data/instruction bus (byte-addressed, Avalon-style, with waitrequest) and the word-indexed single-port RAM.
- The RAM has a one-cycle registered read and whole-word writes only. Partial-word CPU writes are therefore converted into read-modify-write sequences.
- Translates byte addresses to word indices and enforces one outstanding transfer.
- Flags protocol and addressing errors.

Parameters:
- BASE_ADDR, 32'h0000_0000: CPU byte address mapped to RAM word 0.
- DEPTH_WORDS, 4096: number of RAM words; the legal window is BASE_ADDR to BASE_ADDR+4*DEPTH_WORDS-1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  synchronous active-low reset.
- cpu_address  in  32  byte address.
- cpu_read  in  1  read request.
- cpu_write  in  1  write request.
- cpu_byteenable  in  4  bit i enables byte lane writedata[8i+7:8i].
- cpu_writedata  in  32  write data.
- cpu_readdata  out  32  read data; valid in the cycle a read completes.
- cpu_waitrequest  out  1  high = CPU must hold all request signals stable.
- err  out  1  sticky error flag.
- ram_address  out  32  word index = (cpu_address-BASE_ADDR)>>2.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe.
- ram_byteenable  out  4  constant 4'b1111.
- ram_writedata  out  32  word to write.
- ram_readdata  in  32  RAM data, valid the cycle after ram_read.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, err=0, read-data hold register=0.
  - ram_read=ram_write=0 in every cycle reset_n is low.
  - An in-flight transfer is abandoned with no RAM write.
- States: IDLE, RD_WAIT, RMW_MERGE.
- IDLE with no request: waitrequest=0; ram_read=ram_write=0.
- Full write (cpu_write, be=4'b1111):
  - ram_write=1 and ram_writedata=cpu_writedata combinationally; waitrequest=0.
  - Completes in 1 cycle; stays in IDLE.
- Null write (cpu_write, be=0): no RAM access; waitrequest=0; 1 cycle.
- Read (cpu_read):
  - IDLE: ram_read=1, waitrequest=1, go to RD_WAIT.
  - RD_WAIT: ram_read=0, cpu_readdata=ram_readdata, waitrequest=0, capture into the hold register, go to IDLE.
  - Latency 2 cycles. The full word is always returned; cpu_byteenable is ignored for reads.
- Partial write (cpu_write, be not 0000/1111):
  - IDLE: ram_read=1, waitrequest=1, go to RMW_MERGE.
  - RMW_MERGE: ram_write=1; ram_writedata byte i = be[i] ? cpu_writedata byte i : ram_readdata byte i; waitrequest=0; go to IDLE.
  - 2 cycles; the unenabled bytes of the RAM word are preserved.
- Outside RD_WAIT, cpu_readdata = hold register (last completed read; 0 after reset).
- ram_address is always driven combinationally from cpu_address. The CPU holds it stable while waitrequest=1, so it is constant across multi-cycle transfers.
- Errors (each sets err=1; err stays set until reset):
  - cpu_read and cpu_write both high in IDLE: no RAM access, waitrequest=0, readdata unchanged.
  - cpu_address[1:0]!=0: access proceeds on the aligned word.
  - Address outside window: ram_read=ram_write=0. Reads complete in 2 cycles returning 32'h0; writes complete in 1 cycle and are dropped.
- Request deasserted in RD_WAIT/RMW_MERGE (CPU protocol violation): the state still completes and returns to IDLE. An RMW write still occurs using the latched merge inputs.
- Back-to-back transfers: a new request is sampled in the IDLE cycle immediately after completion; there are no bubble cycles beyond those listed.

Decomposition:
- Package mem_bus_pkg:
  - state enum (IDLE, RD_WAIT, RMW_MERGE);
  - BE_ALL=4'b1111, BE_NONE=4'b0000;
  - ADDR_LSB=2.
- Sub-module byte_merge: purely combinational (old_word, new_word, be) -> merged word. It is reused by future cache fill logic.

Test Plan:
- Full write, then read: write 0x100 = 32'hDEADBEEF with be=1111 (1 cycle, waitrequest=0). Read 0x100 -> waitrequest high 1 cycle, then readdata=32'hDEADBEEF.
- Partial write: word 0x200 holds 32'h11223344. Write be=0101, data 32'hAABBCCDD -> 2 cycles, RAM word=32'h11BB33DD. A later read confirms it.
- Null write: write be=0000 to 0x300 holding 32'h55555555 -> 1 cycle, no ram_write, word unchanged, err=0.
- Errors: read+write together -> err=1, no RAM strobes. Read at 0x4000 (DEPTH 4096) -> readdata=0, err=1. Misaligned read at 0x103 -> returns word 0x100, err=1.
- Reset mid-RMW: assert reset_n=0 in the RMW_MERGE cycle -> no ram_write; state=IDLE, err=0, cpu_readdata=0 next cycle.
- Back-to-back: read, partial write, full write, read to distinct addresses with requests held per waitrequest -> total 2+2+1+2 cycles, all data correct.
